// File: rtl/antares_operand_stage_pkg.sv
// Shared definitions for the antares ID->EX operand stage: forward-source
// encoding and the register-address match helper used by the forwarding units.
package antares_defines;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    function automatic logic addr_hit(input logic we, input reg_addr_t wa, input reg_addr_t src);
        return we && (wa == src);
    endfunction

endpackage

// File: rtl/antares_fwd_unit.sv
// Per-operand forwarding decision: selects the newest producer of a source
// register and flags a hazard when that producer cannot deliver yet.
module antares_fwd_unit
    import antares_defines::*;
(
    input  logic      id_valid_i,
    input  reg_addr_t src_i,
    input  logic      used_i,
    input  logic      ex_valid_i,
    input  logic      ex_we_i,
    input  reg_addr_t ex_wa_i,
    input  logic      ex_is_load_i,
    input  logic      mem_we_i,
    input  reg_addr_t mem_wa_i,
    input  logic      mem_is_load_i,
    input  logic      mem_ready_i,
    input  logic      wb_we_i,
    input  reg_addr_t wb_wa_i,
    output fwd_sel_e  fwd_sel_o,
    output logic      hazard_o
);

    logic srcLive;
    logic rawHazard;

    assign srcLive = used_i && (src_i != '0);

    // The first matching stage wins; a load in EX or an unfinished load in
    // MEM cannot supply data this cycle, so that match becomes a hazard.
    always_comb begin
        fwd_sel_o = FWD_RF;
        rawHazard = 1'b0;
        if (srcLive) begin
            if (addr_hit(ex_valid_i && ex_we_i, ex_wa_i, src_i)) begin
                fwd_sel_o = FWD_EX;
                rawHazard = ex_is_load_i;
            end else if (addr_hit(mem_we_i, mem_wa_i, src_i)) begin
                fwd_sel_o = FWD_MEM;
                rawHazard = mem_is_load_i && !mem_ready_i;
            end else if (addr_hit(wb_we_i, wb_wa_i, src_i)) begin
                fwd_sel_o = FWD_WB;
            end
        end
    end

    assign hazard_o = id_valid_i && rawHazard;

endmodule

// File: rtl/antares_operand_stage.sv
// ID->EX operand stage: bypass muxes, hazard stall/bubble control, the ID/EX
// pipeline register and a saturating hazard-stall counter.
module antares_operand_stage
    import antares_defines::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [4:0]            id_rs,
    input  logic [4:0]            id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [4:0]            id_wa,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic [DATA_WIDTH-1:0] gpr_rd_a,
    input  logic [DATA_WIDTH-1:0] gpr_rd_b,
    input  logic [DATA_WIDTH-1:0] ex_alu_result,
    input  logic [4:0]            mem_wa,
    input  logic                  mem_we,
    input  logic                  mem_is_load,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic                  mem_result_ready,
    input  logic [4:0]            wb_wa,
    input  logic                  wb_we,
    input  logic [DATA_WIDTH-1:0] wb_wd,
    input  logic                  ex_stall,
    input  logic                  flush,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic                  ex_we,
    output logic                  ex_is_load,
    output logic [4:0]            ex_wa,
    output logic [DATA_WIDTH-1:0] ex_op_a,
    output logic [DATA_WIDTH-1:0] ex_op_b,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    logic                  exValid_q, exValid_d;
    logic                  exWe_q, exWe_d;
    logic                  exIsLoad_q, exIsLoad_d;
    reg_addr_t             exWa_q, exWa_d;
    logic [DATA_WIDTH-1:0] opA_q, opA_d;
    logic [DATA_WIDTH-1:0] opB_q, opB_d;
    logic [CNT_WIDTH-1:0]  stallCnt_q, stallCnt_d;

    fwd_sel_e              selA, selB;
    logic                  hazA, hazB;
    logic                  hazard;
    logic [DATA_WIDTH-1:0] fwdA, fwdB;

    antares_fwd_unit uFwdRs (
        .id_valid_i    (id_valid),
        .src_i         (id_rs),
        .used_i        (id_uses_rs),
        .ex_valid_i    (exValid_q),
        .ex_we_i       (exWe_q),
        .ex_wa_i       (exWa_q),
        .ex_is_load_i  (exIsLoad_q),
        .mem_we_i      (mem_we),
        .mem_wa_i      (mem_wa),
        .mem_is_load_i (mem_is_load),
        .mem_ready_i   (mem_result_ready),
        .wb_we_i       (wb_we),
        .wb_wa_i       (wb_wa),
        .fwd_sel_o     (selA),
        .hazard_o      (hazA)
    );

    antares_fwd_unit uFwdRt (
        .id_valid_i    (id_valid),
        .src_i         (id_rt),
        .used_i        (id_uses_rt),
        .ex_valid_i    (exValid_q),
        .ex_we_i       (exWe_q),
        .ex_wa_i       (exWa_q),
        .ex_is_load_i  (exIsLoad_q),
        .mem_we_i      (mem_we),
        .mem_wa_i      (mem_wa),
        .mem_is_load_i (mem_is_load),
        .mem_ready_i   (mem_result_ready),
        .wb_we_i       (wb_we),
        .wb_wa_i       (wb_wa),
        .fwd_sel_o     (selB),
        .hazard_o      (hazB)
    );

    assign hazard   = hazA || hazB;
    assign id_stall = hazard || ex_stall;

    always_comb begin
        fwdA = gpr_rd_a;
        case (selA)
            FWD_RF:  fwdA = gpr_rd_a;
            FWD_EX:  fwdA = ex_alu_result;
            FWD_MEM: fwdA = mem_result;
            FWD_WB:  fwdA = wb_wd;
        endcase
    end

    always_comb begin
        fwdB = gpr_rd_b;
        case (selB)
            FWD_RF:  fwdB = gpr_rd_b;
            FWD_EX:  fwdB = ex_alu_result;
            FWD_MEM: fwdB = mem_result;
            FWD_WB:  fwdB = wb_wd;
        endcase
    end

    // Flush kills the entering instruction even under a downstream hold;
    // bubbles clear only control so the operand registers keep their data.
    always_comb begin
        exValid_d  = exValid_q;
        exWe_d     = exWe_q;
        exIsLoad_d = exIsLoad_q;
        exWa_d     = exWa_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        if (flush || (!ex_stall && hazard)) begin
            exValid_d  = 1'b0;
            exWe_d     = 1'b0;
            exIsLoad_d = 1'b0;
        end else if (!ex_stall) begin
            exValid_d  = id_valid;
            exWe_d     = id_we && id_valid;
            exIsLoad_d = id_is_load;
            exWa_d     = id_wa;
            opA_d      = fwdA;
            opB_d      = fwdB;
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (hazard && !ex_stall && !(&stallCnt_q)) begin
            stallCnt_d = stallCnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exValid_q  <= 1'b0;
            exWe_q     <= 1'b0;
            exIsLoad_q <= 1'b0;
            exWa_q     <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            stallCnt_q <= '0;
        end else begin
            exValid_q  <= exValid_d;
            exWe_q     <= exWe_d;
            exIsLoad_q <= exIsLoad_d;
            exWa_q     <= exWa_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign ex_valid    = exValid_q;
    assign ex_we       = exWe_q;
    assign ex_is_load  = exIsLoad_q;
    assign ex_wa       = exWa_q;
    assign ex_op_a     = opA_q;
    assign ex_op_b     = opB_q;
    assign stall_count = stallCnt_q;

endmodule
